ddr3_cmd_arbiter: RTL
=====================

DDR3_CMD_ARBITER -- requirements
Module: ddr3_cmd_arbiter

Interface
REQ-001 Parameter N_CH, default 4: number of command requesters, legal range 2..8.
REQ-002 Parameter ADDR_W, default 27: DDR3 user-interface address width.
REQ-003 Parameter RUN_MAX, default 4: maximum consecutive same-type grants while the other type is pending, legal range 1..255.
REQ-004 clk  in  1: DDR3 user-interface clock; one clock, all logic synchronous to its rising edge.
REQ-005 reset_n  in  1: asynchronous, active-low reset.
REQ-006 acq_enabled  in  1: write commands are grantable only when high; already synchronised to clk.
REQ-007 req_vld  in  N_CH: per-channel command request.
REQ-008 req_cmd  in  3*N_CH: per-channel command; channel i occupies bits [3i+2:3i]; 000 = write, 001 = read.
REQ-009 req_addr  in  ADDR_W*N_CH: per-channel address, packed like req_cmd.
REQ-010 req_rdy  out  N_CH: one-hot acceptance; a channel's command transfers when req_vld & req_rdy.
REQ-011 app_addr  out  ADDR_W: command address to the memory controller.
REQ-012 app_cmd  out  3: command to the memory controller.
REQ-013 app_en  out  1: command valid to the memory controller.
REQ-014 app_rdy  in  1: memory controller accepts the command when app_en & app_rdy.
REQ-015 grant_id  out  $clog2(N_CH): channel that owns the command currently on app_*.
REQ-016 cmd_count  out  32: total commands accepted by the memory controller; wraps modulo 2^32.
REQ-017 busy  out  1: high whenever app_en is high or any req_vld bit is high.

Function
REQ-018 The arbiter shall implement states IDLE (output slot empty) and ISSUE (app_en high, waiting for app_rdy).
REQ-019 A channel is eligible when its req_vld bit is high, and, if its command is a write, acq_enabled is high.
REQ-020 Selection shall be round-robin, starting from pointer rr_ptr; after a grant to channel k, rr_ptr becomes (k+1) mod N_CH.
REQ-021 Run-length rule: once run_cnt reaches RUN_MAX and an eligible request of the opposite type exists, only opposite-type requests shall be eligible for that selection.
REQ-022 run_cnt shall reset to 1 on a type change, increment on a same-type grant, and saturate at RUN_MAX.
REQ-023 When in IDLE with at least one eligible channel, the arbiter shall assert req_rdy for the winner combinationally in that cycle, load its command and address into the output register, and enter ISSUE with app_en high the next cycle.
REQ-024 When in ISSUE with app_rdy high, the command is complete; if an eligible channel exists in the same cycle, the arbiter shall grant and load it, so that app_en stays high and the sustained rate is one command per cycle.
REQ-025 When in ISSUE with app_rdy low, app_addr, app_cmd, app_en and grant_id shall hold stable and req_rdy shall be all zero.
REQ-026 At most one req_rdy bit shall be high in any cycle; req_rdy shall never be high for an ineligible channel.
REQ-027 cmd_count shall increment by 1 on every cycle in which app_en & app_rdy is high.
REQ-028 A deassertion of acq_enabled shall not cancel a write already in the output register; that write shall complete normally.
REQ-029 Encodings of req_cmd other than 000 or 001 shall be treated as reads for run-length purposes and passed through unchanged.
REQ-030 Latency from req_vld (arbiter idle, channel winning) to app_en shall be exactly 1 cycle.

Reset
REQ-031 When reset_n is asserted low, the arbiter shall immediately force state = IDLE, app_en = 0, app_cmd = 000, app_addr = 0, grant_id = 0, rr_ptr = 0, run_cnt = 0, cmd_count = 0 and req_rdy = 0, regardless of any in-flight command.
REQ-032 A command pending on app_* when reset asserts shall be dropped and not counted.
REQ-033 Reset release shall be synchronised externally; the first grant may occur on the first clock edge after release.

Structure
REQ-034 Package ddr3_pkg shall hold the APP_CMD_WR = 000 and APP_CMD_RD = 001 constants and the arbiter state type.
REQ-035 Round-robin selection (eligible mask plus pointer in, one-hot winner plus index out) shall be a sub-module named rr_pick, parametrised by N_CH.
REQ-036 No memory structures shall be used; all storage shall be flops.

Verification (N_CH = 4, ADDR_W = 27, RUN_MAX = 4)
REQ-037 Reset scenario: drive reset_n low mid-ISSUE with app_rdy = 0 -> app_en = 0, cmd_count = 0 and req_rdy = 0000 with no clock edge required.
REQ-038 Round-robin scenario: all 4 channels issue continuous reads with app_rdy = 1 -> grant_id sequence 0,1,2,3,0 on consecutive cycles, and cmd_count = 5 after the fifth acceptance.
REQ-039 Run-length scenario: channel 0 issues continuous writes, channel 1 issues continuous reads, acq_enabled = 1, app_rdy = 1 -> at most 4 consecutive commands of one type, then a switch, with the pattern repeating.
REQ-040 Acquisition-gating scenario: acq_enabled = 0, channel 2 issues a write to address 0x0000100 -> req_rdy[2] stays 0 and app_en stays 0; raising acq_enabled -> app_en = 1 one cycle later with app_addr = 0x0000100.
REQ-041 Backpressure scenario: app_rdy held low for 10 cycles while channel 3 issues a read to address 0x7FFFFFF -> app_addr, app_cmd and grant_id stay constant throughout, and cmd_count increments by exactly 1 when app_rdy rises.
REQ-042 Counter-wrap scenario: preload cmd_count to 0xFFFFFFFF through a force, then one accepted command -> cmd_count = 0x00000000.

Source files
------------

// File: rtl/ddr3_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_pkg
// Shared definitions for the DDR3 command arbiter: memory-controller command
// encodings, the arbiter state type and a small command classification helper.
// ----------------------------------------------------------------------------
package ddr3_pkg;

   localparam logic [2:0] APP_CMD_WR = 3'b000;
   localparam logic [2:0] APP_CMD_RD = 3'b001;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } arb_state_t;

   // Anything that is not the write encoding counts as a read for the
   // run-length bookkeeping; the raw encoding is still forwarded untouched.
   function automatic logic is_wr_cmd(input logic [2:0] cmd);
      return (cmd == APP_CMD_WR);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Round-robin selector: scans the eligible mask starting at ptr and wrapping
// modulo N_CH, returns the first eligible channel.
//
// Ports
//   elig        in   N_CH   eligible-channel mask
//   ptr         in   IDX_W  channel with highest priority this cycle
//   win_onehot  out  N_CH   one-hot winner (all zero when nothing eligible)
//   win_idx     out  IDX_W  binary index of the winner
//   win_any     out  1      at least one channel is eligible
// ----------------------------------------------------------------------------
module rr_pick #(
   parameter int  N_CH  = 4,
   localparam int IDX_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  elig,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_CH-1:0]  win_onehot,
   output logic [IDX_W-1:0] win_idx,
   output logic             win_any
);

   always_comb begin
      logic [IDX_W:0] cand;
      win_onehot = '0;
      win_idx    = '0;
      win_any    = 1'b0;
      cand       = '0;
      for (int off = 0; off < N_CH; off++) begin
         // One extra bit so ptr+off cannot overflow before the modulo fold.
         cand = {1'b0, ptr} + (IDX_W+1)'(off);
         if (cand >= (IDX_W+1)'(N_CH)) begin
            cand = cand - (IDX_W+1)'(N_CH);
         end
         if (!win_any && elig[cand[IDX_W-1:0]]) begin
            win_any                        = 1'b1;
            win_idx                        = cand[IDX_W-1:0];
            win_onehot[cand[IDX_W-1:0]]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// ddr3_cmd_arbiter
// Round-robin arbiter feeding N_CH command requesters into a single DDR3
// memory-controller user interface, one command per cycle at full rate.
// Writes are gated by acq_enabled, and a run-length limiter forces a switch
// between reads and writes after RUN_MAX consecutive same-type grants when
// the other type is waiting.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | output slot empty, app_en low
//   ST_ISSUE | command held on app_*, app_en high, waiting for app_rdy
//
// Ports
//   clk          in   1              user-interface clock
//   reset_n      in   1              asynchronous active-low reset
//   acq_enabled  in   1              writes grantable only while high
//   req_vld      in   N_CH           per-channel request
//   req_cmd      in   3*N_CH         per-channel command, channel i at [3i+2:3i]
//   req_addr     in   ADDR_W*N_CH    per-channel address, packed like req_cmd
//   req_rdy      out  N_CH           one-hot acceptance of a channel command
//   app_addr     out  ADDR_W         address to the memory controller
//   app_cmd      out  3              command to the memory controller
//   app_en       out  1              command valid
//   app_rdy      in   1              memory controller accepts the command
//   grant_id     out  $clog2(N_CH)   channel owning the command on app_*
//   cmd_count    out  32             commands accepted, wraps
//   busy         out  1              app_en high or any request pending
// ----------------------------------------------------------------------------
module ddr3_cmd_arbiter
   import ddr3_pkg::*;
#(
   parameter int  N_CH    = 4,
   parameter int  ADDR_W  = 27,
   parameter int  RUN_MAX = 4,
   localparam int IDX_W   = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     acq_enabled,
   input  logic [N_CH-1:0]          req_vld,
   input  logic [3*N_CH-1:0]        req_cmd,
   input  logic [ADDR_W*N_CH-1:0]   req_addr,
   output logic [N_CH-1:0]          req_rdy,
   output logic [ADDR_W-1:0]        app_addr,
   output logic [2:0]               app_cmd,
   output logic                     app_en,
   input  logic                     app_rdy,
   output logic [IDX_W-1:0]         grant_id,
   output logic [31:0]              cmd_count,
   output logic                     busy
);

   localparam logic [7:0] RUN_LIM = 8'(RUN_MAX);

   arb_state_t        state_q;
   arb_state_t        state_d;

   logic [IDX_W-1:0]  rr_ptr;
   logic [7:0]        run_cnt;
   logic              last_wr;

   logic [N_CH-1:0]   elig_wr;
   logic [N_CH-1:0]   elig_rd;
   logic [N_CH-1:0]   elig;
   logic              run_limit;

   logic [N_CH-1:0]   win_onehot;
   logic [IDX_W-1:0]  win_idx;
   logic              win_any;

   logic [2:0]        sel_cmd;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_wr;
   logic [IDX_W-1:0]  next_ptr;

   logic              slot_free;
   logic              grant;

   // -------------------------------------------------------------------------
   // Eligibility with run-length restriction
   // -------------------------------------------------------------------------
   always_comb begin
      elig_wr = '0;
      elig_rd = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (is_wr_cmd(req_cmd[3*i +: 3])) begin
            elig_wr[i] = req_vld[i] & acq_enabled;
         end else begin
            elig_rd[i] = req_vld[i];
         end
      end
   end

   assign run_limit = (run_cnt >= RUN_LIM);

   // Once the run is exhausted, the opposite type takes over only if it is
   // actually waiting; otherwise the current type keeps the bus.
   always_comb begin
      elig = elig_wr | elig_rd;
      if (run_limit && last_wr && (|elig_rd)) begin
         elig = elig_rd;
      end else if (run_limit && !last_wr && (|elig_wr)) begin
         elig = elig_wr;
      end
   end

   rr_pick #(
      .N_CH (N_CH)
   ) u_rr_pick (
      .elig       (elig),
      .ptr        (rr_ptr),
      .win_onehot (win_onehot),
      .win_idx    (win_idx),
      .win_any    (win_any)
   );

   always_comb begin
      sel_cmd  = APP_CMD_WR;
      sel_addr = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (win_onehot[i]) begin
            sel_cmd  = req_cmd[3*i +: 3];
            sel_addr = req_addr[ADDR_W*i +: ADDR_W];
         end
      end
   end

   assign sel_wr   = is_wr_cmd(sel_cmd);
   assign next_ptr = (win_idx == IDX_W'(N_CH-1)) ? '0 : win_idx + 1'b1;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (app_rdy && !grant) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs
   // -------------------------------------------------------------------------
   // The slot frees up either when empty or when the held command is being
   // accepted this very cycle, which is what gives back-to-back issue.
   // reset_n gates the grant so req_rdy drops the instant reset asserts.
   always_comb begin
      slot_free = 1'b0;
      app_en    = 1'b0;
      case (state_q)
         ST_IDLE:  slot_free = 1'b1;
         ST_ISSUE: begin
            app_en    = 1'b1;
            slot_free = app_rdy;
         end
         default: ;
      endcase
      grant   = reset_n & slot_free & win_any;
      req_rdy = grant ? win_onehot : '0;
   end

   // -------------------------------------------------------------------------
   // Output register, pointer and run-length tracking
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         app_addr <= '0;
         app_cmd  <= APP_CMD_WR;
         grant_id <= '0;
         rr_ptr   <= '0;
         run_cnt  <= '0;
         last_wr  <= 1'b0;
      end else if (grant) begin
         app_addr <= sel_addr;
         app_cmd  <= sel_cmd;
         grant_id <= win_idx;
         rr_ptr   <= next_ptr;
         last_wr  <= sel_wr;
         // run_cnt == 0 only before the first grant after reset.
         if ((run_cnt == '0) || (sel_wr != last_wr)) begin
            run_cnt <= 8'd1;
         end else if (run_cnt < RUN_LIM) begin
            run_cnt <= run_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_count <= '0;
      end else if (app_en && app_rdy) begin
         cmd_count <= cmd_count + 32'd1;
      end
   end

   assign busy = app_en | (|req_vld);

endmodule
